pool2d_stream: RTL and testbench

//  Streaming 2-D pooling engine: successor to the fixed 16-byte combinational pooling block.

---
 rtl/pool2d_stream.sv | 144 ++++++++++++++
 tb/tb_pool2d_stream.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool2d_stream.sv
// Streaming 2-D pooling engine: row-major pixels in, one max or floor-average result per
// POOL x POOL window out, with a single-entry output register and ready/valid handshakes.
module pool2d_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4,
    parameter int POOL   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int LOG_P = $clog2(POOL);
    localparam int SH    = 2 * LOG_P;
    localparam int ACC_W = DATA_W + SH;
    localparam int NACC  = IMG_W / POOL;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int IDX_W = (NACC > 1) ? $clog2(NACC) : 1;

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic              r_mode;
    logic              r_busy;
    logic [ACC_W-1:0]  r_acc [NACC];
    logic [DATA_W-1:0] r_res_p1;
    logic              r_vld_p1;
    logic              r_last_p1;

    logic              w_accept;
    logic              w_hs;
    logic              w_first;
    logic              w_load;
    logic              w_close;
    logic              w_col_end;
    logic              w_row_end;
    logic              w_last_pix;
    logic              w_mode;
    logic [IDX_W-1:0]  w_idx;
    logic [ACC_W-1:0]  w_acc;
    logic [ACC_W-1:0]  w_in;
    logic [ACC_W-1:0]  w_new;
    logic [DATA_W-1:0] w_res;

    function automatic logic [ACC_W-1:0] f_combine(input logic avg,
                                                   input logic [ACC_W-1:0] a,
                                                   input logic [ACC_W-1:0] b);
        if (avg)
            return a + b;
        return (a > b) ? a : b;
    endfunction

    // Average divides by POOL*POOL with a plain shift (floor); max passes straight through.
    function automatic logic [DATA_W-1:0] f_finalize(input logic avg,
                                                     input logic [ACC_W-1:0] v);
        logic [ACC_W-1:0] t;
        t = avg ? (v >> SH) : v;
        return t[DATA_W-1:0];
    endfunction

    assign in_ready   = !(r_vld_p1 && !out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_hs       = r_vld_p1 && out_ready;

    assign w_first    = (r_row == '0) && (r_col == '0);
    assign w_load     = (r_row[LOG_P-1:0] == '0) && (r_col[LOG_P-1:0] == '0);
    assign w_close    = (&r_row[LOG_P-1:0]) && (&r_col[LOG_P-1:0]);
    assign w_col_end  = (r_col == COL_W'(IMG_W - 1));
    assign w_row_end  = (r_row == ROW_W'(IMG_H - 1));
    assign w_last_pix = w_col_end && w_row_end;

    // The frame's first pixel must already use the mode being latched with it.
    assign w_mode     = w_first ? mode : r_mode;
    assign w_idx      = IDX_W'(r_col >> LOG_P);
    assign w_acc      = r_acc[w_idx];
    assign w_in       = {{SH{1'b0}}, in_data};
    assign w_new      = w_load ? w_in : f_combine(w_mode, w_acc, w_in);
    assign w_res      = f_finalize(w_mode, w_new);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col  <= '0;
            r_row  <= '0;
            r_mode <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= w_row_end ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                if (w_first)
                    r_mode <= mode;
            end
            // A new frame starting on the same edge as the previous frame's last handshake keeps busy high.
            if (w_accept && w_first)
                r_busy <= 1'b1;
            else if (w_hs && r_last_p1)
                r_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NACC; i++)
                r_acc[i] <= '0;
        end else if (w_accept) begin
            r_acc[w_idx] <= w_new;
        end
    end

    // Stage p1: window result register, loaded by the closing pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_res_p1  <= '0;
            r_last_p1 <= 1'b0;
        end else if (w_accept && w_close) begin
            r_vld_p1  <= 1'b1;
            r_res_p1  <= w_res;
            r_last_p1 <= w_last_pix;
        end else if (w_hs) begin
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
        end
    end

    assign out_valid = r_vld_p1;
    assign out_data  = r_res_p1;
    assign out_last  = r_last_p1;
    assign busy      = r_busy;

endmodule

// File: tb/tb_pool2d_stream.sv
// Self-checking bench for pool2d_stream: directed frames plus randomized back-to-back frames
// compared against a window-level max / floor-average reference model.
module tb_pool2d_stream;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int P  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;

    int            n_chk  = 0;
    int            n_fail = 0;
    int            cyc    = 0;

    logic [7:0]    frm      [64];
    bit            frm_mode [64];
    logic [7:0]    q_d   [$];
    logic          q_l   [$];
    int            q_hs  [$];
    int            q_acc [$];
    logic [7:0]    exp_d [$];
    logic          exp_l [$];
    bit            rnd_gap = 1'b0;
    bit            rnd_bp  = 1'b0;

    pool2d_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .POOL(P)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every result handshake (taken on the following rising edge).
    always begin
        @(negedge clk);
        #2;
        if (rst_n && out_valid && out_ready) begin
            q_d.push_back(out_data);
            q_l.push_back(out_last);
            q_hs.push_back(cyc + 1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic clear();
        q_d.delete(); q_l.delete(); q_hs.delete(); q_acc.delete();
        exp_d.delete(); exp_l.delete();
    endtask

    task automatic load_spec(input int base, input bit m);
        logic [7:0] s [16];
        s = '{8'd1, 8'd4, 8'd3, 8'd5, 8'd2, 8'd1, 8'd1, 8'd3,
              8'd6, 8'd0, 8'd2, 8'd0, 8'd2, 8'd5, 8'd6, 8'd7};
        for (int i = 0; i < 16; i++) begin
            frm[base + i]      = s[i];
            frm_mode[base + i] = m;
        end
    endtask

    // Reference: each window is the max or floor(sum / P^2) of its pixels, mode from pixel (0,0).
    task automatic build_exp(input int base);
        for (int wr = 0; wr < H / P; wr++) begin
            for (int wc = 0; wc < W / P; wc++) begin
                int mx;
                int sm;
                mx = 0;
                sm = 0;
                for (int dr = 0; dr < P; dr++) begin
                    for (int dc = 0; dc < P; dc++) begin
                        int v;
                        v = int'(frm[base + (wr * P + dr) * W + wc * P + dc]);
                        if (v > mx) mx = v;
                        sm += v;
                    end
                end
                exp_d.push_back(frm_mode[base] ? 8'(sm / (P * P)) : 8'(mx));
                exp_l.push_back((wr == H / P - 1) && (wc == W / P - 1));
            end
        end
    endtask

    task automatic send(input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            int guard;
            @(negedge clk);
            if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
            while (rnd_gap && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
                if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
            end
            in_valid = 1'b1;
            in_data  = frm[i];
            mode     = frm_mode[i];
            #1;
            guard = 0;
            while (!in_ready) begin
                @(negedge clk);
                if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
                #1;
                guard++;
                if (guard > 200) begin
                    $display("FAIL send_stall: pixel %0d in_ready=%0b after %0d cycles, required 1", i, in_ready, guard);
                    $fatal(1, "input stalled");
                end
            end
            q_acc.push_back(cyc + 1);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        int g;
        g = 0;
        rnd_bp = 1'b0;
        while (q_d.size() < n && g < 200) begin
            @(negedge clk);
            out_ready = 1'b1;
            #3;
            g++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_chk += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        if (out_data !== 8'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d, required 0", out_data); end
        if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b, required 0", out_last); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_chk++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    endtask

    task automatic test_max();
        clear();
        load_spec(0, 1'b0);
        build_exp(0);
        send(0, 1);
        @(posedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL max_busy_set: got %b, required 1", busy); end
        send(1, 15);
        idle();
        drain(4);
        n_chk++;
        if (q_d.size() != 4) begin n_fail++; $display("FAIL max_count: got %0d results, required 4", q_d.size()); end
        for (int i = 0; i < 4; i++) begin
            int close;
            close = ((i / 2) * P + P - 1) * W + (i % 2) * P + P - 1;
            n_chk += 2;
            if (q_d[i] !== exp_d[i] || q_l[i] !== exp_l[i]) begin
                n_fail++;
                $display("FAIL max_result[%0d]: got data=%0d last=%b, required data=%0d last=%b", i, q_d[i], q_l[i], exp_d[i], exp_l[i]);
            end
            if (q_hs[i] - q_acc[close] != 1) begin
                n_fail++;
                $display("FAIL max_latency[%0d]: got %0d cycles, required 1", i, q_hs[i] - q_acc[close]);
            end
        end
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL max_busy_clear: got %b, required 0", busy); end
    endtask

    task automatic test_avg();
        clear();
        load_spec(0, 1'b1);
        build_exp(0);
        send(0, 16);
        idle();
        drain(4);
        n_chk++;
        if (q_d.size() != 4) begin n_fail++; $display("FAIL avg_count: got %0d results, required 4", q_d.size()); end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (q_d[i] !== exp_d[i] || q_l[i] !== exp_l[i]) begin
                n_fail++;
                $display("FAIL avg_result[%0d]: got data=%0d last=%b, required data=%0d last=%b", i, q_d[i], q_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear();
        load_spec(0, 1'b0);
        build_exp(0);
        fork
            send(0, 16);
            begin
                int g;
                g = 0;
                while (!out_valid && g < 100) begin
                    @(posedge clk);
                    #1;
                    g++;
                end
                @(negedge clk);
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    #2;
                    n_chk++;
                    if (out_valid !== 1'b1 || out_data !== 8'd4 || in_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL bp_hold[%0d]: got valid=%b data=%0d in_ready=%b, required valid=1 data=4 in_ready=0", k, out_valid, out_data, in_ready);
                    end
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        idle();
        drain(4);
        n_chk += 2;
        if (q_acc.size() != 16) begin n_fail++; $display("FAIL bp_pixels: got %0d accepted, required 16", q_acc.size()); end
        if (q_d.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d results, required 4", q_d.size()); end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (q_d[i] !== exp_d[i] || q_l[i] !== exp_l[i]) begin
                n_fail++;
                $display("FAIL bp_result[%0d]: got data=%0d last=%b, required data=%0d last=%b", i, q_d[i], q_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_saturate();
        clear();
        for (int i = 0; i < 16; i++) begin
            frm[i] = 8'd255;
            frm_mode[i] = 1'b1;
        end
        build_exp(0);
        send(0, 16);
        idle();
        drain(4);
        n_chk++;
        if (q_d.size() != 4) begin n_fail++; $display("FAIL sat_count: got %0d results, required 4", q_d.size()); end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (q_d[i] !== exp_d[i]) begin
                n_fail++;
                $display("FAIL sat_result[%0d]: got %0d, required %0d", i, q_d[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_mode_toggle();
        clear();
        load_spec(0, 1'b0);
        for (int i = 3; i < 16; i++) frm_mode[i] = 1'b1;
        load_spec(16, 1'b1);
        build_exp(0);
        build_exp(16);
        send(0, 17);
        @(posedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b, required 1", busy); end
        send(17, 15);
        idle();
        drain(8);
        n_chk++;
        if (q_d.size() != 8) begin n_fail++; $display("FAIL toggle_count: got %0d results, required 8", q_d.size()); end
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (q_d[i] !== exp_d[i] || q_l[i] !== exp_l[i]) begin
                n_fail++;
                $display("FAIL toggle_result[%0d]: got data=%0d last=%b, required data=%0d last=%b", i, q_d[i], q_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        clear();
        load_spec(0, 1'b0);
        send(0, 6);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== 8'd4) begin
            n_fail++;
            $display("FAIL mid_pending: got valid=%b data=%0d, required valid=1 data=4", out_valid, out_data);
        end
        rst_n = 1'b0;
        #1;
        n_chk += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b, required 0", out_valid); end
        if (out_data !== 8'd0) begin n_fail++; $display("FAIL mid_rst_data: got %0d, required 0", out_data); end
        if (out_last !== 1'b0) begin n_fail++; $display("FAIL mid_rst_last: got %b, required 0", out_last); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b, required 0", busy); end
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear();
        load_spec(0, 1'b0);
        build_exp(0);
        send(0, 16);
        idle();
        drain(4);
        n_chk++;
        if (q_d.size() != 4) begin n_fail++; $display("FAIL mid_count: got %0d results, required 4", q_d.size()); end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (q_d[i] !== exp_d[i] || q_l[i] !== exp_l[i]) begin
                n_fail++;
                $display("FAIL mid_result[%0d]: got data=%0d last=%b, required data=%0d last=%b", i, q_d[i], q_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            clear();
            for (int f = 0; f < 3; f++) begin
                for (int i = 0; i < 16; i++) begin
                    frm[f * 16 + i]      = 8'($urandom_range(0, 255));
                    frm_mode[f * 16 + i] = 1'($urandom_range(0, 1));
                end
                build_exp(f * 16);
            end
            rnd_gap = 1'b1;
            rnd_bp  = 1'b1;
            send(0, 48);
            rnd_gap = 1'b0;
            idle();
            drain(12);
            n_chk++;
            if (q_d.size() != 12) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d results, required 12", it, q_d.size()); end
            for (int i = 0; i < 12; i++) begin
                n_chk++;
                if (q_d[i] !== exp_d[i] || q_l[i] !== exp_l[i]) begin
                    n_fail++;
                    $display("FAIL rnd_result[%0d][%0d]: got data=%0d last=%b, required data=%0d last=%b", it, i, q_d[i], q_l[i], exp_d[i], exp_l[i]);
                end
            end
            n_chk++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %b, required 0", it, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_avg();
        test_backpressure();
        test_saturate();
        test_mode_toggle();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
